// File: rtl/risc16_fetch_unit.sv
// RiSC-16 instruction-fetch sequencer: owns the PC, reads a combinational
// instruction memory and buffers up to two {pc, instr} words for decode.
// Optional HALT detection is built when RISC16_FETCH_HALT_EN is defined.
module risc16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  logic [15:0] fetch_pc_reg;
  logic [1:0]  count_reg;
  logic [15:0] head_pc_reg;
  logic [15:0] head_instr_reg;
  logic [15:0] tail_pc_reg;
  logic [15:0] tail_instr_reg;
  logic        halt_seen;
  logic        pop;
  logic        push;

  always_comb begin
    pop  = (count_reg != 2'd0) && out_ready;
    push = !redirect_valid && !halt_seen && ((count_reg < 2'd2) || pop);
  end

`ifdef RISC16_FETCH_HALT_EN
  logic halt_seen_reg;
  logic is_halt;

  // HALT is the JALR opcode with a non-zero immediate field.
  always_comb begin
    is_halt = (imem_data[15:13] == 3'b111) && (imem_data[6:0] != 7'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_seen_reg <= 1'b0;
    end else if (redirect_valid) begin
      halt_seen_reg <= 1'b0;
    end else if (push && is_halt) begin
      halt_seen_reg <= 1'b1;
    end
  end

  assign halt_seen = halt_seen_reg;
`else
  assign halt_seen = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg   <= RESET_PC;
      count_reg      <= 2'd0;
      head_pc_reg    <= 16'h0000;
      head_instr_reg <= 16'h0000;
      tail_pc_reg    <= 16'h0000;
      tail_instr_reg <= 16'h0000;
    end else if (redirect_valid) begin
      // Flush: head/tail contents become don't-care once count is zero.
      fetch_pc_reg <= redirect_pc;
      count_reg    <= 2'd0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + 16'd1;
      end
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_pc_reg    <= fetch_pc_reg;
            head_instr_reg <= imem_data;
          end else begin
            tail_pc_reg    <= fetch_pc_reg;
            tail_instr_reg <= imem_data;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_pc_reg    <= tail_pc_reg;
          head_instr_reg <= tail_instr_reg;
          count_reg      <= count_reg - 2'd1;
        end
        2'b11: begin
          // With one entry the new word becomes head; with two it shifts in behind.
          if (count_reg == 2'd1) begin
            head_pc_reg    <= fetch_pc_reg;
            head_instr_reg <= imem_data;
          end else begin
            head_pc_reg    <= tail_pc_reg;
            head_instr_reg <= tail_instr_reg;
            tail_pc_reg    <= fetch_pc_reg;
            tail_instr_reg <= imem_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr = fetch_pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_instr = head_instr_reg;
  assign out_pc    = head_pc_reg;
  assign halted    = halt_seen && (count_reg == 2'd0);

endmodule

// File: doc/risc16_fetch_unit.md
# risc16_fetch_unit

Instruction-fetch sequencer for the RiSC-16 core. It owns the program counter, drives the address of the combinational-read instruction memory, and buffers fetched words in a 2-entry FIFO. Decode consumes them over a valid/ready handshake. Execute redirects it on taken branches and JALR, which flushes any in-flight fetched words.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  16  instruction memory address; always equals fetch_pc.
- imem_data  input  16  instruction word at imem_addr, valid in the same cycle (combinational memory).
- out_valid  output  1  head of the fetch buffer holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  16  instruction word at the buffer head.
- out_pc  output  16  address the head instruction was fetched from.
- redirect_valid  input  1  execute requests a fetch redirect.
- redirect_pc  input  16  redirect target address.
- halted  output  1  fetch has stopped on a HALT and the buffer has drained (see Configuration).

## Operation
State:
- fetch_pc (16 bits).
- 2-entry FIFO of {pc, instr} with count 0..2.
- halt_seen flag.

Behaviour:
- pop = out_valid && out_ready.
- push = !redirect_valid && !halt_seen && (count < 2 || pop).
  - On push, write {fetch_pc, imem_data} to the tail and set fetch_pc <= fetch_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Simultaneous push and pop: count is unchanged; order is preserved.
- Redirect has priority over everything else:
  - Buffer is flushed (count <= 0).
  - fetch_pc <= redirect_pc.
  - halt_seen <= 0.
  - No push that cycle.
  - A pop in the same cycle still counts as accepted by decode; its word is retired normally.
- out_valid = (count != 0).
- out_instr and out_pc come from FIFO head registers. They are held stable while out_valid && !out_ready.
- With count == 0, out_instr and out_pc are don't-care. They shall read 16'h0000 after reset until the first push.

## Timing
- Reset (asynchronous):
  - fetch_pc = RESET_PC, imem_addr = RESET_PC.
  - count = 0, out_valid = 0, out_instr = 0, out_pc = 0.
  - halt_seen = 0, halted = 0.
- First rising edge after rst deasserts: pushes the word at RESET_PC. out_valid rises in the following cycle (1-cycle fetch latency).
- Steady state with out_ready held high: one instruction delivered per cycle, consecutive PCs, no bubbles.
- out_ready low: the buffer fills to 2, then fetch_pc holds and no memory word is consumed. When out_ready rises, the stream resumes without loss or duplication.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N+1.
  - imem_addr = redirect_pc in N+1.
  - Target instruction appears on the outputs in N+2.
- Reset mid-stream discards buffer contents immediately, with no clock edge required.

## Configuration
- Macro RISC16_FETCH_HALT_EN.
- Defined:
  - A pushed word with instr[15:13] == 3'b111 and instr[6:0] != 0 is a RiSC-16 HALT. It sets halt_seen on that push, which stops further pushes.
  - The HALT word itself is still delivered to decode.
  - halted = halt_seen && count == 0.
  - A redirect clears halt_seen and resumes fetch.
- Undefined:
  - halt_seen stays 0 and halted is tied 0.
  - HALT encodings are fetched like any other word.

## Test plan
- Reset with RESET_PC = 16'h0010, mem[0x10..0x13] = 1,2,3,4, out_ready = 1 -> out_valid rises 1 cycle after reset release; (pc, instr) = (0x10,1), (0x11,2), (0x12,3), (0x13,4) on consecutive cycles.
- Backpressure: out_ready = 0 for 5 cycles from the first valid -> count saturates at 2 and imem_addr holds at head pc + 2. When out_ready returns to 1 the sequence continues with no gap or repeat.
- Redirect to 0x0100 while count == 2 and pop == 1 -> the popped word is accepted. Next cycle out_valid = 0 and imem_addr = 0x0100. The cycle after, out_pc = 0x0100.
- Wrap: RESET_PC = 16'hFFFF -> delivered PCs are 0xFFFF then 0x0000.
- With RISC16_FETCH_HALT_EN, mem[2] = 16'hE001 -> words at 0, 1 and 2 are delivered and word 3 never is; halted = 1 once drained. A redirect to 0 clears halted and refetches from 0. Without the macro, word 3 is delivered.
- Assert rst while count == 2 -> outputs return to reset values before the next clock edge.
